// File: rtl/branch_resolve_e.sv
// rtl/branch_resolve_e.sv - execute-stage branch resolver with 2-bit predictor table and perf counters
module branch_resolve_e #(
    parameter int INDEX_BITS = 6
) (
    input  logic        iClk,
    input  logic        iRstN,
    input  logic [31:0] iPCF,
    output logic        oPredictTakenF,
    input  logic        iBranchE,
    input  logic        iStallE,
    input  logic [31:0] iPCE,
    input  logic        iPredTakenE,
    input  logic        iActualTakenE,
    input  logic [31:0] iTargetE,
    input  logic [31:0] iPCPlus4E,
    output logic        oMispredictE,
    output logic [31:0] oRedirectPCE,
    output logic [31:0] oBranchCount,
    output logic [31:0] oMispredictCount
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [1:0]            predTable [ENTRIES];
    logic [INDEX_BITS-1:0] idxF;
    logic [INDEX_BITS-1:0] idxE;
    logic [1:0]            curEntry;
    logic [1:0]            nextEntry;
    logic                  resolveE;
    logic [31:0]           branchCount;
    logic [31:0]           mispredictCount;

    assign idxF     = iPCF[INDEX_BITS+1:2];
    assign idxE     = iPCE[INDEX_BITS+1:2];
    assign resolveE = iBranchE & ~iStallE;
    assign curEntry = predTable[idxE];

    // Fetch reads registered state only; a same-cycle write from execute is not bypassed.
    assign oPredictTakenF   = predTable[idxF][1];
    assign oBranchCount     = branchCount;
    assign oMispredictCount = mispredictCount;

    always_comb begin
        oMispredictE = 1'b0;
        oRedirectPCE = 32'd0;
        if (resolveE && (iPredTakenE != iActualTakenE)) begin
            oMispredictE = 1'b1;
            oRedirectPCE = iActualTakenE ? iTargetE : iPCPlus4E;
        end
    end

    // Saturating 2-bit step toward the resolved direction.
    always_comb begin
        nextEntry = curEntry;
        if (iActualTakenE) begin
            if (curEntry != 2'b11) nextEntry = curEntry + 2'd1;
        end else begin
            if (curEntry != 2'b00) nextEntry = curEntry - 2'd1;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            for (int i = 0; i < ENTRIES; i++) begin
                predTable[i[INDEX_BITS-1:0]] <= 2'b01;
            end
            branchCount     <= 32'd0;
            mispredictCount <= 32'd0;
        end else if (resolveE) begin
            predTable[idxE] <= nextEntry;
            branchCount     <= branchCount + 32'd1;
            if (oMispredictE) begin
                mispredictCount <= mispredictCount + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_e.sv
// tb/tb_branch_resolve_e.sv - directed scoreboard bench for branch_resolve_e
module tb_branch_resolve_e;

    localparam int IB = 6;
    localparam int N  = 1 << IB;

    logic        iClk;
    logic        iRstN;
    logic [31:0] iPCF;
    logic        oPredictTakenF;
    logic        iBranchE;
    logic        iStallE;
    logic [31:0] iPCE;
    logic        iPredTakenE;
    logic        iActualTakenE;
    logic [31:0] iTargetE;
    logic [31:0] iPCPlus4E;
    logic        oMispredictE;
    logic [31:0] oRedirectPCE;
    logic [31:0] oBranchCount;
    logic [31:0] oMispredictCount;

    branch_resolve_e #(.INDEX_BITS(IB)) dut (
        .iClk            (iClk),
        .iRstN           (iRstN),
        .iPCF            (iPCF),
        .oPredictTakenF  (oPredictTakenF),
        .iBranchE        (iBranchE),
        .iStallE         (iStallE),
        .iPCE            (iPCE),
        .iPredTakenE     (iPredTakenE),
        .iActualTakenE   (iActualTakenE),
        .iTargetE        (iTargetE),
        .iPCPlus4E       (iPCPlus4E),
        .oMispredictE    (oMispredictE),
        .oRedirectPCE    (oRedirectPCE),
        .oBranchCount    (oBranchCount),
        .oMispredictCount(oMispredictCount)
    );

    typedef struct {
        logic        mis;
        logic [31:0] redir;
    } exp_t;

    exp_t        sbq[$];
    logic [1:0]  mTable [N];
    logic [31:0] mBr;
    logic [31:0] mMis;
    int          errors = 0;
    int          checks = 0;

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    function automatic int idx(input logic [31:0] pc);
        return int'(pc[IB+1:2]);
    endfunction

    function automatic logic mPred(input logic [31:0] pc);
        logic [1:0] e;
        e = mTable[idx(pc)];
        return e[1];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < N; i++) mTable[i] = 2'b01;
        mBr  = 32'd0;
        mMis = 32'd0;
    endtask

    // Drive one cycle at the falling edge, check combinational and registered outputs, then advance the model.
    task automatic step(input logic br, input logic st, input logic [31:0] pce,
                        input logic pt, input logic at, input logic [31:0] tgt,
                        input logic [31:0] pc4, input logic [31:0] pcf, input string tag);
        exp_t e;
        logic res;
        @(negedge iClk);
        iBranchE      = br;
        iStallE       = st;
        iPCE          = pce;
        iPredTakenE   = pt;
        iActualTakenE = at;
        iTargetE      = tgt;
        iPCPlus4E     = pc4;
        iPCF          = pcf;
        res           = br & ~st;
        e.mis         = res & (pt != at);
        e.redir       = e.mis ? (at ? tgt : pc4) : 32'd0;
        sbq.push_back(e);
        #1;
        e = sbq.pop_front();
        check({tag, ".mis"},   32'(oMispredictE),   32'(e.mis));
        check({tag, ".redir"}, oRedirectPCE,        e.redir);
        check({tag, ".pred"},  32'(oPredictTakenF), 32'(mPred(pcf)));
        check({tag, ".brcnt"}, oBranchCount,        mBr);
        check({tag, ".miscnt"}, oMispredictCount,   mMis);
        if (res) begin
            if (at && mTable[idx(pce)] != 2'b11) mTable[idx(pce)] = mTable[idx(pce)] + 2'd1;
            if (!at && mTable[idx(pce)] != 2'b00) mTable[idx(pce)] = mTable[idx(pce)] - 2'd1;
            mBr = mBr + 32'd1;
            if (e.mis) mMis = mMis + 32'd1;
        end
    endtask

    task automatic idle(input logic [31:0] pcf, input string tag);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, pcf, tag);
    endtask

    initial begin
        iRstN = 1'b0; iPCF = 32'h40; iBranchE = 1'b0; iStallE = 1'b0; iPCE = 32'd0;
        iPredTakenE = 1'b0; iActualTakenE = 1'b0; iTargetE = 32'd0; iPCPlus4E = 32'd0;
        modelReset();
        #2;
        check("rst.pred",   32'(oPredictTakenF), 32'd0);
        check("rst.brcnt",  oBranchCount, 32'd0);
        check("rst.miscnt", oMispredictCount, 32'd0);
        check("rst.mis",    32'(oMispredictE), 32'd0);
        check("rst.redir",  oRedirectPCE, 32'd0);
        @(negedge iClk);
        iRstN = 1'b1;

        // Train weak-NT entry at 0x40 toward taken with a mispredict.
        step(1'b1, 1'b0, 32'h40, 1'b0, 1'b1, 32'h10, 32'h44, 32'h40, "train");
        idle(32'h40, "trainAfter");

        // Saturation on index 5 in both directions, back-to-back.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h14, mPred(32'h14), 1'b1, 32'h200, 32'h18, 32'h14, "satT");
        step(1'b1, 1'b0, 32'h14, mPred(32'h14), 1'b0, 32'h200, 32'h18, 32'h14, "satN1");
        idle(32'h14, "satWeakT");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h14, mPred(32'h14), 1'b0, 32'h200, 32'h18, 32'h14, "satN");
        idle(32'h14, "satFloor");

        // Correctly predicted taken branch.
        step(1'b1, 1'b0, 32'h40, 1'b1, 1'b1, 32'h10, 32'h44, 32'h40, "correct");
        idle(32'h40, "correctAfter");

        // Not-taken mispredict held under stall, then released.
        step(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h500, 32'h104, 32'h100, "stall0");
        step(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h500, 32'h104, 32'h100, "stall1");
        step(1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 32'h500, 32'h104, 32'h100, "unstall");
        idle(32'h100, "unstallAfter");

        // Index 0 is now 00; push to 01 then alias write 01->10 while fetch reads index 0.
        step(1'b1, 1'b0, 32'h200, 1'b0, 1'b1, 32'h600, 32'h204, 32'h0, "preAlias");
        step(1'b1, 1'b0, 32'h100, 1'b0, 1'b1, 32'h700, 32'h104, 32'h0, "alias");
        idle(32'h0, "aliasAfter");

        // Branch counter wrap.
        @(negedge iClk);
        force dut.branchCount = 32'hFFFF_FFFF;
        #1;
        release dut.branchCount;
        mBr = 32'hFFFF_FFFF;
        step(1'b1, 1'b0, 32'h40, 1'b1, 1'b1, 32'h10, 32'h44, 32'h40, "wrap");
        idle(32'h40, "wrapAfter");

        // Asynchronous reset during a pending mispredict discards training and the increment.
        @(negedge iClk);
        iBranchE = 1'b1; iStallE = 1'b0; iPCE = 32'h14; iPredTakenE = 1'b0;
        iActualTakenE = 1'b1; iTargetE = 32'h900; iPCPlus4E = 32'h18; iPCF = 32'h40;
        #1;
        check("midRst.misBefore", 32'(oMispredictE), 32'd1);
        iRstN = 1'b0;
        #1;
        modelReset();
        check("midRst.pred",   32'(oPredictTakenF), 32'd0);
        check("midRst.brcnt",  oBranchCount, 32'd0);
        check("midRst.miscnt", oMispredictCount, 32'd0);
        @(negedge iClk);
        check("midRst.brcntHeld",  oBranchCount, 32'd0);
        check("midRst.miscntHeld", oMispredictCount, 32'd0);
        iBranchE = 1'b0;
        iRstN = 1'b1;
        idle(32'h40, "postRst40");
        idle(32'h14, "postRst14");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_resolve_e.md
# branch_resolve_e

Execute-stage branch resolver and dynamic predictor table. It is the write/resolve end of the fetch-stage branch prediction path. It holds a table of 2-bit saturating counters that fetch reads to predict conditional branches. It compares each resolved branch in execute against the prediction carried down the pipeline, raises mispredict/redirect to the hazard unit, trains the table, and keeps performance counters.

## Interface
- INDEX_BITS, 6 — table has 2^INDEX_BITS entries; index = PC[INDEX_BITS+1:2]
- iClk  in  1  clock; all state updates on rising edge
- iRstN  in  1  asynchronous, active-low reset
- iPCF  in  32  fetch PC, read-port address
- oPredictTakenF  out  1  table[idx(iPCF)][1]; combinational read of registered state
- iBranchE  in  1  valid conditional branch (opcode 7'd99) in execute this cycle
- iStallE  in  1  execute stalled; suppresses all updates and outputs
- iPCE  in  32  PC of execute instruction
- iPredTakenE  in  1  prediction made in fetch, carried through F/D and D/E registers
- iActualTakenE  in  1  resolved branch condition from ALU
- iTargetE  in  32  resolved branch target (PC + imm)
- iPCPlus4E  in  32  fall-through address
- oMispredictE  out  1  combinational; flush F/D and D/E this cycle
- oRedirectPCE  out  32  combinational; correct next PC when oMispredictE=1, else 0
- oBranchCount  out  32  registered count of resolved branches
- oMispredictCount  out  32  registered count of mispredictions

## Operation
- Table: 2^INDEX_BITS × 2-bit counters. States 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction = bit[1].
- Resolve event = iBranchE & ~iStallE.
- oMispredictE = resolve event & (iPredTakenE != iActualTakenE).
- oRedirectPCE = iActualTakenE ? iTargetE : iPCPlus4E when oMispredictE; 32'b0 otherwise.
- On a resolve event, at the edge, table[idx(iPCE)] is updated:
  - taken: +1, saturating at 11.
  - not taken: −1, saturating at 00.
- No update when iBranchE=0 or iStallE=1. Non-branch instructions never touch the table.
- oBranchCount +1 on every resolve event.
- oMispredictCount +1 when oMispredictE=1.
- Both counters wrap modulo 2^32 (FFFFFFFF → 0).
- iPredTakenE is trusted as supplied. The block does not re-read the table for execute, because the entry may have been trained since fetch.

## Timing
- Reset (iRstN low, asynchronous): every table entry = 01, oBranchCount = 0, oMispredictCount = 0. Outputs settle immediately, without waiting for a clock edge:
  - oPredictTakenF = 0.
  - oMispredictE and oRedirectPCE are 0 whenever iBranchE=0.
- Reset asserted mid-operation discards all training. A pending mispredict during reset produces no counter increment.
- Read latency 0: oPredictTakenF follows iPCF combinationally.
- Write latency 1: an update is visible at the read port from the cycle after the resolve edge.
- Same index read in F and written from E in the same cycle: fetch sees the pre-update value. There is no bypass.
- oMispredictE and oRedirectPCE are valid in the same cycle as the resolve event. The hazard unit must flush and redirect on that cycle's edge.
- Counter and table updates occur on that same edge. oBranchCount and oMispredictCount reflect the event from the next cycle.
- Stall with iBranchE held: nothing updates and oMispredictE=0. The event is counted exactly once, on the first unstalled cycle.
- Back-to-back resolve events on the same index each apply one step, e.g. 01 → 10 → 11.

## Test plan
- Reset, then read: iRstN=0 → all entries 01; iPCF=0x0000_0040 → oPredictTakenF=0; both counters 0.
- Training to taken: iBranchE=1, iPCE=0x0000_0040, iActualTakenE=1, iPredTakenE=0, iTargetE=0x0000_0010.
  - Cycle 1: oMispredictE=1, oRedirectPCE=0x0000_0010.
  - Next cycle, iPCF=0x40: oPredictTakenF=1, oBranchCount=1, oMispredictCount=1.
- Saturation: four taken resolves on index 5 (PC 0x14) → entry 11.
  - One not-taken resolve → 10, prediction still 1.
  - Three more not-taken resolves → 00; a further not-taken stays at 00.
- Correct prediction: iPredTakenE=1, iActualTakenE=1 → oMispredictE=0, oRedirectPCE=0; oBranchCount +1, oMispredictCount unchanged.
- Not-taken mispredict with stall:
  - iPredTakenE=1, iActualTakenE=0, iPCPlus4E=0x0000_0104, iStallE=1 for 2 cycles → no output, no update.
  - Then iStallE=0 → oMispredictE=1, oRedirectPCE=0x0000_0104; counters increment exactly once.
- Aliasing and simultaneous read/write:
  - Resolve taken at iPCE=0x100 (index 0) while iPCF=0x000 (index 0) → oPredictTakenF shows the old bit that cycle and the new bit the next cycle.
  - Force oBranchCount to 0xFFFF_FFFF, then resolve → it wraps to 0.
